conv_sched: RTL and testbench
=============================

# conv_sched

Sequencing controller for the convolution engine's 7-row × 32-pixel shifting register file and its multiply/reduction pipeline. Traverses a frame in 32-pixel-wide tile columns and issues one-row-word fetch requests. Drives `rowShift` and `colShift` into the register file, flags cycles where the window is valid, and delays that flag through the engine pipeline to produce `oValid` and `oDone`.

## Interface
Parameters:
- `width`, 1920: frame width in pixels; multiple of 32; `NT = width/32` tile columns.
- `height`, 1080: frame height in rows; must be ≥ 7.
- `pipelineDepth`, 9: engine latency from window-valid to result-valid.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `iStart`  in  1  one-cycle frame start pulse.
- `mode`  in  3  `pattern_3x3` / `pattern_5x5` / `pattern_7x7` (params.v encodings); latched at start.
- `iValid`  in  1  requested 256-bit row word is present on the register-file input this cycle.
- `oReq`  out  1  one-cycle fetch request.
- `oReqRow`  out  11  row index of request.
- `oReqTile`  out  6  tile column of request.
- `rowShift`  out  1  load `iData` into row 6 and shift rows up.
- `colShift`  out  1  rotate every row by the mode step.
- `oWinValid`  out  1  window in rows 0..K-1 is a valid output position.
- `oValid`  out  1  `oWinValid` delayed `pipelineDepth` cycles.
- `oBusy`  out  1  high from the accepted start until `oDone`.
- `oDone`  out  1  one-cycle pulse when the frame's last result leaves the pipeline.

## Operation
- Mode-derived constants:
  - 3x3: K=3, step=4 px, S=8 shifts per row.
  - 5x5: K=5, step=1, S=28.
  - 7x7: K=7, step=1, S=26.
  - R = S·step (32, 28, 26); realign count A = 32−R (0, 4, 6).
  - Any other `mode` code is treated as 7x7.
- Output rows per tile: `OR = height−K+1`.
- Fetched rows per tile: `7 + OR − 1`. Requested index `r ≥ height` is clamped to `oReqRow = height−1` (edge replicate).
- FSM states: IDLE, FILL, SHIFT, REALIGN, FETCH, FLUSH.
  - IDLE: on `iStart`, latch `mode`, clear counters, set `oBusy`, go to FILL.
  - FILL: request rows 0..6 of the current tile, one outstanding at a time. Each `iValid` gives `rowShift`=1 that cycle. After the 7th `iValid`, go to SHIFT.
  - SHIFT: S cycles, each with `oWinValid`=1 and `colShift`=1. Then go to REALIGN if A>0, otherwise skip it.
  - REALIGN: A cycles with `colShift`=1 and `oWinValid`=0, restoring full 32-px rotation.
  - Exit of SHIFT/REALIGN:
    - more output rows remain → FETCH;
    - else more tiles remain → increment tile, reset row counter, go to FILL;
    - else → FLUSH.
  - FETCH: request the next row (`outRow+7`, clamped). On `iValid`, `rowShift`=1, then go to SHIFT.
  - FLUSH: wait until the valid pipeline is empty. Pulse `oDone`, clear `oBusy`, return to IDLE.
- Request rule: `oReq` pulses the first cycle of a wait. The next `oReq` comes no earlier than the cycle after `iValid`.
- Ignored inputs:
  - `iValid` while no request is outstanding;
  - `iStart` while `oBusy`;
  - `mode` changes mid-frame.
- `rowShift` and `colShift` are never high in the same cycle.

## Timing
- Reset values: all outputs 0, FSM = IDLE, counters 0, valid pipeline cleared.
- `reset` asserted mid-frame aborts immediately, and no `oDone` is produced.
- `oReq` comes 1 cycle after `iStart` (first FILL cycle). `oReqRow`/`oReqTile` are valid while `oReq` is high.
- `rowShift` is combinational from `iValid` in FILL/FETCH (same cycle).
- SHIFT is entered the cycle after the final `iValid`. `oWinValid` and `colShift` are registered outputs of the state.
- `oValid` equals `oWinValid` from exactly `pipelineDepth` cycles earlier.
- `oDone` is high 1 cycle after the last `oValid`.
- Frame totals:
  - windows = NT·OR·S;
  - requests = NT·(7+OR−1).

## Test plan
- Frame size 64×9, 7x7, `iValid` 1 cycle after every `oReq`:
  - 18 requests; rows per tile are 0..8.
  - 156 `oValid` cycles.
  - 6 REALIGN `colShift`s per output row.
  - `oDone` 1 cycle after the last `oValid`.
- Frame size 64×9, 3x3:
  - 112 windows, no REALIGN.
  - Per tile, the requests are rows 0..8, then 8,8,8,8 (clamped).
- 5x5 with random 0–5 cycle `iValid` latency:
  - never more than one outstanding request;
  - windows = 2·5·28 = 280;
  - `rowShift` count equals `iValid` count.
- Spurious inputs:
  - an `iValid` while no request is outstanding causes no `rowShift`;
  - `iStart` while busy is ignored;
  - a `mode` change mid-frame has no effect.
- Async `reset` in the middle of SHIFT:
  - all outputs drop to 0 without waiting for a clock edge;
  - a subsequent `iStart` runs a full correct frame.

Source files
------------

// File: rtl/conv_sched.sv
// conv_sched: tile-column sequencer for the 7x32 shifting register file.
// Issues row fetches, drives row/column shifts and tracks the result pipeline.
module conv_sched #(
    parameter int width         = 1920,
    parameter int height        = 1080,
    parameter int pipelineDepth = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iStart,
    input  logic [2:0]  mode,
    input  logic        iValid,
    output logic        oReq,
    output logic [10:0] oReqRow,
    output logic [5:0]  oReqTile,
    output logic        rowShift,
    output logic        colShift,
    output logic        oWinValid,
    output logic        oValid,
    output logic        oBusy,
    output logic        oDone
);

    localparam logic [2:0] pattern_3x3 = 3'd0;
    localparam logic [2:0] pattern_5x5 = 3'd1;
    localparam logic [2:0] pattern_7x7 = 3'd2;

    localparam int          NT        = width / 32;
    localparam logic [5:0]  TILE_LAST = 6'(NT - 1);
    localparam logic [11:0] ROW_LAST  = 12'(height - 1);
    localparam logic [11:0] HEIGHT    = 12'(height);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SHIFT,
        REALIGN,
        FETCH,
        FLUSH
    } state_t;

    state_t state;
    state_t nextState;
    state_t rowExit;

    logic [2:0]  modeQ;
    logic [2:0]  fillCnt;
    logic [4:0]  cnt;
    logic [11:0] outRow;
    logic [5:0]  tile;
    logic        pending;

    logic [pipelineDepth-1:0] vpipe;

    logic [2:0]  kSize;
    logic [4:0]  sLast;
    logic [2:0]  aCnt;
    logic [4:0]  aLast;
    logic [11:0] orLast;
    logic [11:0] fetchRow;
    logic [10:0] reqRow;
    logic        accept;
    logic        shiftEnd;
    logic        realignEnd;
    logic        rowEnd;
    logic        lastRow;
    logic        lastTile;

    // Window size, shifts per row and realign count for the latched mode
    always_comb begin
        kSize = 3'd7;
        sLast = 5'd25;
        aCnt  = 3'd6;
        unique case (1'b1)
            (modeQ == pattern_3x3): begin
                kSize = 3'd3;
                sLast = 5'd7;
                aCnt  = 3'd0;
            end
            (modeQ == pattern_5x5): begin
                kSize = 3'd5;
                sLast = 5'd27;
                aCnt  = 3'd4;
            end
            (modeQ == pattern_7x7): begin
                kSize = 3'd7;
                sLast = 5'd25;
                aCnt  = 3'd6;
            end
            default: begin
                kSize = 3'd7;
                sLast = 5'd25;
                aCnt  = 3'd6;
            end
        endcase
    end

    // Row/tile bookkeeping and request address with bottom-edge clamp
    always_comb begin
        aLast      = {2'b00, aCnt} - 5'd1;
        orLast     = HEIGHT - {9'd0, kSize};
        lastRow    = (outRow == orLast);
        lastTile   = (tile == TILE_LAST);
        accept     = pending && iValid &&
                     ((state == FILL) || (state == FETCH));
        shiftEnd   = (state == SHIFT) && (cnt == sLast);
        realignEnd = (state == REALIGN) && (cnt == aLast);
        rowEnd     = (shiftEnd && (aCnt == 3'd0)) || realignEnd;
        fetchRow   = outRow + 12'd7;
        if (state == FILL)
            reqRow = {8'd0, fillCnt};
        else if (fetchRow > ROW_LAST)
            reqRow = ROW_LAST[10:0];
        else
            reqRow = fetchRow[10:0];
        if (!lastRow)
            rowExit = FETCH;
        else if (!lastTile)
            rowExit = FILL;
        else
            rowExit = FLUSH;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= nextState;
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:
                if (iStart)
                    nextState = FILL;
            FILL:
                if (accept && (fillCnt == 3'd6))
                    nextState = SHIFT;
            SHIFT:
                if (shiftEnd)
                    nextState = (aCnt != 3'd0) ? REALIGN : rowExit;
            REALIGN:
                if (realignEnd)
                    nextState = rowExit;
            FETCH:
                if (accept)
                    nextState = SHIFT;
            FLUSH:
                if (vpipe == '0)
                    nextState = IDLE;
            default:
                nextState = IDLE;
        endcase
    end

    // Outputs decoded from state; rowShift follows iValid in the same cycle
    always_comb begin
        oReq      = ((state == FILL) || (state == FETCH)) && !pending;
        oReqRow   = oReq ? reqRow : 11'd0;
        oReqTile  = oReq ? tile : 6'd0;
        rowShift  = accept;
        colShift  = (state == SHIFT) || (state == REALIGN);
        oWinValid = (state == SHIFT);
        oBusy     = (state != IDLE);
        oDone     = (state == FLUSH) && (vpipe == '0);
        oValid    = vpipe[pipelineDepth-1];
    end

    // Frame counters, mode latch and the single-outstanding request flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            modeQ   <= 3'd0;
            fillCnt <= 3'd0;
            cnt     <= 5'd0;
            outRow  <= 12'd0;
            tile    <= 6'd0;
            pending <= 1'b0;
        end else begin
            if ((state == IDLE) && iStart) begin
                modeQ   <= mode;
                fillCnt <= 3'd0;
                cnt     <= 5'd0;
                outRow  <= 12'd0;
                tile    <= 6'd0;
                pending <= 1'b0;
            end
            if (oReq)
                pending <= 1'b1;
            else if (accept)
                pending <= 1'b0;
            if (accept && (state == FILL))
                fillCnt <= (fillCnt == 3'd6) ? 3'd0 : fillCnt + 3'd1;
            if (accept && (state == FETCH))
                outRow <= outRow + 12'd1;
            if (state == SHIFT)
                cnt <= shiftEnd ? 5'd0 : cnt + 5'd1;
            if (state == REALIGN)
                cnt <= realignEnd ? 5'd0 : cnt + 5'd1;
            if (rowEnd && lastRow && !lastTile) begin
                tile   <= tile + 6'd1;
                outRow <= 12'd0;
            end
        end
    end

    // Window-valid delay line matching the engine latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vpipe <= '0;
        end else begin
            vpipe[0] <= oWinValid;
            for (int i = 1; i < pipelineDepth; i++)
                vpipe[i] <= vpipe[i-1];
        end
    end

endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: random-latency frames for conv_sched checked against
// a schedule model built from the mode table and frame geometry.
module tb_conv_sched;

    localparam int W  = 64;
    localparam int H  = 9;
    localparam int D  = 9;
    localparam int NT = W / 32;
    localparam logic [2:0] M3 = 3'd0;
    localparam logic [2:0] M5 = 3'd1;
    localparam logic [2:0] M7 = 3'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic        iStart;
    logic [2:0]  mode;
    logic        iValid;
    logic        oReq;
    logic [10:0] oReqRow;
    logic [5:0]  oReqTile;
    logic        rowShift;
    logic        colShift;
    logic        oWinValid;
    logic        oValid;
    logic        oBusy;
    logic        oDone;

    int n_pass  = 0;
    int n_total = 0;
    bit hist [0:8191];

    conv_sched #(
        .width(W),
        .height(H),
        .pipelineDepth(D)
    ) dut (
        .clk(clk),
        .reset(reset),
        .iStart(iStart),
        .mode(mode),
        .iValid(iValid),
        .oReq(oReq),
        .oReqRow(oReqRow),
        .oReqTile(oReqTile),
        .rowShift(rowShift),
        .colShift(colShift),
        .oWinValid(oWinValid),
        .oValid(oValid),
        .oBusy(oBusy),
        .oDone(oDone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int all_outs();
        return int'({oReq, oReqRow, oReqTile, rowShift, colShift,
                     oWinValid, oValid, oBusy, oDone});
    endfunction

    task automatic run_frame(input logic [2:0] m, input int max_lat,
                             input bit spur, input int abort_win);
        int k, s, step, a, orows, rpt;
        int req_q[$];
        int cyc, waitc, acc, win_left, real_left, last_win, done_cyc;
        int n_win, n_val, n_req, n_real, n_row, n_iv;
        int bad_win, bad_col, bad_val, bad_row, bad_both, bad_busy;
        int bad_out;
        bit outst, e_win, e_col, e_val, e_row;
        case (m)
            M3:      begin k = 3; s = 8;  step = 4; end
            M5:      begin k = 5; s = 28; step = 1; end
            default: begin k = 7; s = 26; step = 1; end
        endcase
        a     = 32 - s * step;
        orows = H - k + 1;
        rpt   = 7 + orows - 1;
        for (int t = 0; t < NT; t++)
            for (int r = 0; r < rpt; r++)
                req_q.push_back(t * 2048 + ((r < H) ? r : H - 1));
        for (int i = 0; i < 8192; i++)
            hist[i] = 1'b0;
        waitc = 0; acc = 0; win_left = 0; real_left = 0;
        last_win = 0; done_cyc = -1; outst = 1'b0;
        n_win = 0; n_val = 0; n_req = 0; n_real = 0; n_row = 0; n_iv = 0;
        bad_win = 0; bad_col = 0; bad_val = 0; bad_row = 0;
        bad_both = 0; bad_busy = 0; bad_out = 0;
        @(negedge clk);
        iStart = 1'b1;
        mode   = m;
        iValid = 1'b0;
        cyc    = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            iStart = 1'b0;
            iValid = 1'b0;
            e_row  = 1'b0;
            e_win  = 1'b0;
            e_col  = 1'b0;
            if (win_left > 0) begin
                e_win = 1'b1;
                e_col = 1'b1;
                win_left--;
                last_win = cyc;
            end else if (real_left > 0) begin
                e_col = 1'b1;
                real_left--;
            end
            hist[cyc] = e_win;
            e_val = (cyc >= D) ? hist[cyc-D] : 1'b0;
            bad_win  += int'(oWinValid != e_win);
            bad_col  += int'(colShift != e_col);
            bad_val  += int'(oValid != e_val);
            bad_busy += int'(oBusy != 1'b1);
            n_win    += int'(oWinValid);
            n_val    += int'(oValid);
            n_real   += int'(colShift && !oWinValid);
            if (cyc == 1)
                chk("req_after_start", int'(oReq), 1);
            if (oReq) begin
                n_req++;
                bad_out += int'(outst);
                if (req_q.size() > 0)
                    chk("req_row_tile", int'({oReqTile, oReqRow}),
                        req_q.pop_front());
                else
                    chk("req_extra", 1, 0);
                outst = 1'b1;
                waitc = (max_lat > 0) ? $urandom_range(0, max_lat) : 0;
            end else if (outst) begin
                if (waitc == 0) begin
                    iValid = 1'b1;
                    e_row  = 1'b1;
                    outst  = 1'b0;
                    n_iv++;
                    acc++;
                    if (acc >= 7) begin
                        win_left  = s;
                        real_left = a;
                    end
                    if (acc == rpt)
                        acc = 0;
                end else begin
                    waitc--;
                end
            end else if (spur && $urandom_range(0, 7) == 0) begin
                iValid = 1'b1;
            end
            if (spur && req_q.size() > 0 && $urandom_range(0, 15) == 0)
                iStart = 1'b1;
            if (spur && $urandom_range(0, 7) == 0)
                mode = 3'($urandom_range(0, 7));
            #1;
            bad_row  += int'(rowShift != e_row);
            bad_both += int'(rowShift && colShift);
            n_row    += int'(rowShift);
            if (abort_win > 0 && n_win == abort_win) begin
                reset = 1'b1;
                #1;
                chk("reset_async_outputs", all_outs(), 0);
                iValid = 1'b0;
                iStart = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    chk("reset_held_outputs", all_outs(), 0);
                end
                reset = 1'b0;
                return;
            end
            if (oDone) begin
                done_cyc = cyc;
                break;
            end
            if (cyc >= 6000) begin
                chk("timeout", 1, 0);
                break;
            end
        end
        iStart = 1'b0;
        iValid = 1'b0;
        chk("done_cycle", done_cyc, last_win + D + 1);
        chk("windows", n_win, NT * orows * s);
        chk("ovalid_count", n_val, NT * orows * s);
        chk("requests", n_req, NT * rpt);
        chk("realign_shifts", n_real, NT * orows * a);
        chk("rowshift_eq_ivalid", n_row, n_iv);
        chk("rowshift_count", n_row, NT * rpt);
        chk("win_timing_errs", bad_win, 0);
        chk("colshift_timing_errs", bad_col, 0);
        chk("ovalid_timing_errs", bad_val, 0);
        chk("rowshift_errs", bad_row, 0);
        chk("row_col_overlap", bad_both, 0);
        chk("busy_errs", bad_busy, 0);
        chk("overlapping_reqs", bad_out, 0);
        chk("reqs_left", req_q.size(), 0);
        @(negedge clk);
        chk("busy_cleared", int'(oBusy), 0);
        chk("done_single_pulse", int'(oDone), 0);
    endtask

    initial begin
        reset  = 1'b1;
        iStart = 1'b0;
        iValid = 1'b0;
        mode   = M7;
        repeat (3) @(negedge clk);
        chk("reset_state", all_outs(), 0);
        reset = 1'b0;
        run_frame(M7, 0, 1'b0, 0);
        run_frame(M3, 0, 1'b0, 0);
        run_frame(M5, 5, 1'b1, 0);
        run_frame(M7, 2, 1'b1, 40);
        run_frame(M7, 3, 1'b1, 0);
        run_frame(3'd6, 1, 1'b1, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
